// File: rtl/seq_div_restoring.sv
// rtl/seq_div_restoring.sv - sequential N-bit unsigned restoring divider, one quotient bit per clock
module seq_div_restoring #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   d_q, d_d;
  // A restored remainder is always below the divisor, so only the shifted
  // trial value needs the extra top bit; the stored remainder fits in N bits.
  logic [N-1:0]   r_q, r_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [N:0]     r_shift;
  logic [N:0]     trial;
  logic [N-1:0]   q_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    r_shift = {r_q, q_q[N-1]};
    q_shift = {q_q[N-2:0], 1'b0};
    trial   = r_shift - {1'b0, d_q};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            q_d     = dividend;
            d_d     = divisor;
            r_d     = '0;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!trial[N]) begin
          r_d = trial[N-1:0];
          q_d = q_shift | {{(N-1){1'b0}}, 1'b1};
        end else begin
          r_d = r_shift[N-1:0];
          q_d = q_shift;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          quot_d  = q_d;
          rem_d   = r_d;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q == S_CALC);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_restoring.sv
// tb/tb_seq_div_restoring.sv - directed and small random checks of seq_div_restoring (N=8)
module tb_seq_div_restoring;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_cmp;
  int n_err;

  seq_div_restoring #(.N(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Accept on edge 0, then sample cycles 1..lat+2 at the falling edge.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] qe, input logic [7:0] re, input logic dbz_e,
                         input logic repulse);
    int lat;
    lat = (b == 8'd0) ? 1 : 9;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= lat + 2; k++) begin
      @(negedge clk);
      check($sformatf("%s.busy@%0d", tag, k), 32'(busy), 32'((b != 8'd0) && (k <= 8)));
      check($sformatf("%s.done@%0d", tag, k), 32'(done), 32'(k == lat));
      if (repulse && (k == 3 || k == 9)) begin
        start    = 1'b1;
        dividend = 8'd99;
        divisor  = 8'd2;
      end else begin
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
      end
    end
    check({tag, ".quot"}, 32'(quotient), 32'(qe));
    check({tag, ".rem"}, 32'(remainder), 32'(re));
    check({tag, ".dbz"}, 32'(div_by_zero), 32'(dbz_e));
  endtask

  initial begin
    logic [7:0] ra, rb;
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.quot", 32'(quotient), 32'd0);
    check("rst.rem", 32'(remainder), 32'd0);
    check("rst.dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    run_div("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0);
    run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0);
    run_div("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b0);
    run_div("d100_0", 8'd100, 8'd0, 8'd255, 8'd100, 1'b1, 1'b0);
    run_div("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0);
    run_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b0);
    run_div("d0_13", 8'd0, 8'd13, 8'd0, 8'd0, 1'b0, 1'b0);
    run_div("d254_255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 1'b0);
    run_div("repulse", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b1);

    // Asynchronous reset in the middle of cycle 4 of a run.
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.done", 32'(done), 32'd0);
    check("arst.quot", 32'(quotient), 32'd0);
    check("arst.rem", 32'(remainder), 32'd0);
    check("arst.dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_div("d77_10", 8'd77, 8'd10, 8'd7, 8'd7, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = (i % 25 == 0) ? 8'd0 : 8'($urandom);
      if (rb == 8'd0)
        run_div($sformatf("rnd%0d", i), ra, rb, 8'hFF, ra, 1'b1, 1'b0);
      else
        run_div($sformatf("rnd%0d", i), ra, rb, ra / rb, ra % rb, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
